// File: rtl/pipeline_controller_pkg.sv
// Shared types for the five-stage pipeline stall/flush sequencer.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    PIPE_RUN      = 2'd0,
    PIPE_MEM_WAIT = 2'd1,
    PIPE_FAULT    = 2'd2
  } rv32_pipe_state;

  // One valid bit per stage behind IF; IF itself is governed by the fetch input.
  typedef struct packed {
    logic id;
    logic ex;
    logic ma;
    logic wb;
  } stage_valid_t;

  // Normal advance: every stage moves one step, fetch result lands in ID.
  function automatic stage_valid_t shiftPipe(stage_valid_t v, logic fetchValid);
    stage_valid_t r;
    r.id = fetchValid;
    r.ex = v.id;
    r.ma = v.ex;
    r.wb = v.ma;
    return r;
  endfunction

  // Load-use bubble: ID holds, a bubble enters EX, the back end keeps moving.
  function automatic stage_valid_t bubbleEx(stage_valid_t v);
    stage_valid_t r;
    r.id = v.id;
    r.ex = 1'b0;
    r.ma = v.ex;
    r.wb = v.ma;
    return r;
  endfunction

  // Redirect: the branch in EX moves on to MA, the two younger slots are killed.
  function automatic stage_valid_t killFront(stage_valid_t v);
    stage_valid_t r;
    r.id = 1'b0;
    r.ex = 1'b0;
    r.ma = 1'b1;
    r.wb = v.ma;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer: tracks stage valids, freezes the pipe on
// load-use hazards and data-memory waits, kills wrong-path work on EX
// redirects and turns an overlong memory wait into a one-cycle fault.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_imem_valid,
  input  logic i_hazard,
  input  logic i_redirect,
  input  logic i_ma_mem,
  input  logic i_dmem_ready,
  output logic o_stall_if,
  output logic o_stall_id,
  output logic o_stall_ex,
  output logic o_stall_ma,
  output logic o_pc_sel,
  output logic o_fault,
  output logic o_valid_id,
  output logic o_valid_ex,
  output logic o_valid_ma,
  output logic o_valid_wb
);

  localparam int CNT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rv32_pipe_state   state_q, state_d;
  stage_valid_t     valid_q, valid_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  logic memWait;
  logic runStep;
  logic stallIf, stallId, stallEx, stallMa, pcSel, fault;

  // Next-state and Mealy control outputs; a pending memory access outranks
  // redirect, which outranks the load-use hazard.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    waitCnt_d = waitCnt_q;
    stallIf   = 1'b0;
    stallId   = 1'b0;
    stallEx   = 1'b0;
    stallMa   = 1'b0;
    pcSel     = 1'b0;
    fault     = 1'b0;
    runStep   = 1'b0;
    memWait   = valid_q.ma && i_ma_mem && !i_dmem_ready;

    case (state_q)
      PIPE_RUN: begin
        if (memWait) begin
          stallIf    = 1'b1;
          stallId    = 1'b1;
          stallEx    = 1'b1;
          stallMa    = 1'b1;
          valid_d.wb = 1'b0;
          waitCnt_d  = CNT_ONE;
          state_d    = PIPE_MEM_WAIT;
        end else begin
          runStep = 1'b1;
        end
      end
      PIPE_MEM_WAIT: begin
        if (i_dmem_ready) begin
          runStep   = 1'b1;
          waitCnt_d = '0;
          state_d   = PIPE_RUN;
        end else begin
          stallIf = 1'b1;
          stallId = 1'b1;
          stallEx = 1'b1;
          stallMa = 1'b1;
          if (waitCnt_q == CNT_MAX) begin
            state_d = PIPE_FAULT;
          end else begin
            waitCnt_d = waitCnt_q + CNT_ONE;
          end
        end
      end
      PIPE_FAULT: begin
        fault     = 1'b1;
        pcSel     = 1'b1;
        valid_d   = '0;
        waitCnt_d = '0;
        state_d   = PIPE_RUN;
      end
      default: begin
        valid_d   = '0;
        waitCnt_d = '0;
        state_d   = PIPE_RUN;
      end
    endcase

    // Ordinary pipeline motion, shared by PIPE_RUN and the resume cycle of a wait.
    if (runStep) begin
      if (i_redirect && valid_q.ex) begin
        pcSel   = 1'b1;
        valid_d = killFront(valid_q);
      end else if (i_hazard && valid_q.id) begin
        stallIf = 1'b1;
        stallId = 1'b1;
        valid_d = bubbleEx(valid_q);
      end else begin
        valid_d = shiftPipe(valid_q, i_imem_valid);
      end
    end
  end

  // Reset silences every combinational control output immediately.
  always_comb begin
    o_stall_if = stallIf && !i_rst;
    o_stall_id = stallId && !i_rst;
    o_stall_ex = stallEx && !i_rst;
    o_stall_ma = stallMa && !i_rst;
    o_pc_sel   = pcSel   && !i_rst;
    o_fault    = fault   && !i_rst;
  end

  // State, wait counter and stage valids, with synchronous reset taking priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= PIPE_RUN;
      valid_q   <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign o_valid_id = valid_q.id;
  assign o_valid_ex = valid_q.ex;
  assign o_valid_ma = valid_q.ma;
  assign o_valid_wb = valid_q.wb;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomised scoreboard bench for pipeline_controller.
module tb_pipeline_controller;

  localparam int MAXW = 4;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst, imemValid, hazard, redirect, maMem, dmemReady;
  logic stallIf, stallId, stallEx, stallMa, pcSel, fault;
  logic validId, validEx, validMa, validWb;

  typedef struct {
    logic [9:0] exp;
    logic [9:0] mask;
    int         cyc;
  } expEntry_t;

  expEntry_t sbQueue[$];
  int errors = 0;
  int checks = 0;

  // Reference model: occupancy of ID, EX, MA, WB plus how many cycles the
  // current data access has stalled so far.
  bit occ[4];
  int memStall = 0;
  bit faultNext = 1'b0;

  pipeline_controller #(.MAX_MEM_WAIT(MAXW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_imem_valid(imemValid),
    .i_hazard    (hazard),
    .i_redirect  (redirect),
    .i_ma_mem    (maMem),
    .i_dmem_ready(dmemReady),
    .o_stall_if  (stallIf),
    .o_stall_id  (stallId),
    .o_stall_ex  (stallEx),
    .o_stall_ma  (stallMa),
    .o_pc_sel    (pcSel),
    .o_fault     (fault),
    .o_valid_id  (validId),
    .o_valid_ex  (validEx),
    .o_valid_ma  (validMa),
    .o_valid_wb  (validWb)
  );

  always #5 clk = ~clk;

  // Expected outputs for this cycle from the rules, then advance the model.
  task automatic modelStep(input bit r, input bit fv, input bit hz, input bit rd,
                           input bit mm, input bit rdy,
                           output logic [9:0] exp, output logic [9:0] mask);
    bit [3:0] stalls;
    bit ps, ft;
    bit n[4];
    stalls = 4'b0000;
    ps = 1'b0;
    ft = 1'b0;
    mask = 10'h3FF;
    n = occ;
    if (r) begin
      mask = 10'h3F0;
      n = '{0, 0, 0, 0};
      memStall = 0;
      faultNext = 1'b0;
    end else if (faultNext) begin
      ft = 1'b1;
      ps = 1'b1;
      n = '{0, 0, 0, 0};
      faultNext = 1'b0;
      memStall = 0;
    end else if (memStall > 0 && !rdy) begin
      stalls = 4'b1111;
      memStall++;
      if (memStall == MAXW + 1) faultNext = 1'b1;
    end else if (memStall == 0 && occ[2] && mm && !rdy) begin
      stalls = 4'b1111;
      n[3] = 1'b0;
      memStall = 1;
    end else begin
      memStall = 0;
      if (rd && occ[1]) begin
        ps = 1'b1;
        n = '{0, 0, 1, occ[2]};
      end else if (hz && occ[0]) begin
        stalls = 4'b1100;
        n = '{occ[0], 0, occ[1], occ[2]};
      end else begin
        n = '{fv, occ[0], occ[1], occ[2]};
      end
    end
    exp = {stalls, ps, ft, occ[0], occ[1], occ[2], occ[3]};
    occ = n;
  endtask

  task automatic applyStimulus(input int cyc, input bit r, input bit fv, input bit hz,
                               input bit rd, input bit mm, input bit rdy);
    expEntry_t e;
    rst = r;
    imemValid = fv;
    hazard = hz;
    redirect = rd;
    maMem = mm;
    dmemReady = rdy;
    modelStep(r, fv, hz, rd, mm, rdy, e.exp, e.mask);
    e.cyc = cyc;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input expEntry_t e);
    logic [9:0] act;
    act = {stallIf, stallId, stallEx, stallMa, pcSel, fault,
           validId, validEx, validMa, validWb};
    checks++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      errors++;
      $display("[TB] FAIL outs cycle %0d: got %b expected %b (mask %b)",
               e.cyc, act, e.exp, e.mask);
    end
  endtask

  // Monitor: compares one expected entry per cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  // Driver: directed reset and fill, then randomised traffic with phases of
  // slow memory so that long waits and faults occur.
  initial begin
    bit r, fv, hz, rd, mm, rdy;
    int readyPct;
    rst = 1'b1;
    imemValid = 1'b0;
    hazard = 1'b0;
    redirect = 1'b0;
    maMem = 1'b0;
    dmemReady = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c < 3) begin
        applyStimulus(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (c < 10) begin
        applyStimulus(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        readyPct = ((c % 400) < 300) ? 70 : 8;
        r   = ($urandom_range(0, 199) == 0);
        fv  = ($urandom_range(0, 99) < 80);
        hz  = ($urandom_range(0, 99) < 15);
        rd  = ($urandom_range(0, 99) < 10);
        mm  = ($urandom_range(0, 99) < 45);
        rdy = ($urandom_range(0, 99) < readyPct);
        applyStimulus(c, r, fv, hz, rd, mm, rdy);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sbQueue.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
